// File: rtl/hip_wb_router.sv
// Single-master Wishbone router: decodes host accesses into N_SLAVES windows,
// forwards one registered transaction at a time, and answers misses/timeouts with ERR_DATA.
module hip_wb_router #(
  parameter int          N_SLAVES       = 4,
  parameter logic [7:0]  BASE_HI        = 8'h30,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [N_SLAVES-1:0]      s_cyc_o,
  output logic [N_SLAVES-1:0]      s_stb_o,
  output logic                     s_we_o,
  output logic [3:0]               s_sel_o,
  output logic [15:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  input  logic [N_SLAVES-1:0]      s_ack_i,
  input  logic [32*N_SLAVES-1:0]   s_dat_i,
  output logic                     fault_pulse_o,
  output logic [7:0]               fault_count_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  NS       = 5'(N_SLAVES);

  state_t        state;
  logic          resp_phase;
  logic [15:0]   timer;
  logic [31:0]   resp_data;

  logic [3:0]          idx;
  logic                hit;
  logic [N_SLAVES-1:0] onehot;
  logic                slot_ack;
  logic [31:0]         slot_dat;
  logic                unused_adr_bits;

  assign idx             = wbs_adr_i[19:16];
  assign hit             = (wbs_adr_i[31:24] == BASE_HI) && ({1'b0, idx} < NS);
  assign unused_adr_bits = ^wbs_adr_i[23:20];

  // s_cyc_o is one-hot on the latched window, so it doubles as the ack/data select.
  assign slot_ack = |(s_ack_i & s_cyc_o);

  always_comb begin
    onehot   = '0;
    slot_dat = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      onehot[k] = (idx == 4'(k));
      if (s_cyc_o[k]) slot_dat = s_dat_i[32*k +: 32];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      resp_phase    <= 1'b0;
      timer         <= '0;
      resp_data     <= '0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      s_cyc_o       <= '0;
      s_stb_o       <= '0;
      s_we_o        <= 1'b0;
      s_sel_o       <= '0;
      s_adr_o       <= '0;
      s_dat_o       <= '0;
      fault_pulse_o <= 1'b0;
      fault_count_o <= '0;
    end else begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      fault_pulse_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            s_we_o     <= wbs_we_i;
            s_sel_o    <= wbs_sel_i;
            s_adr_o    <= wbs_adr_i[15:0];
            s_dat_o    <= wbs_dat_i;
            timer      <= '0;
            resp_phase <= 1'b0;
            if (hit) begin
              s_cyc_o <= onehot;
              s_stb_o <= onehot;
              state   <= ACTIVE;
            end else begin
              resp_data     <= ERR_DATA;
              fault_pulse_o <= 1'b1;
              if (fault_count_o != 8'hFF) fault_count_o <= fault_count_o + 8'd1;
              state         <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!wbs_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (slot_ack) begin
            // An ack on the last timeout cycle still wins over the timeout.
            resp_data <= slot_dat;
            s_cyc_o   <= '0;
            s_stb_o   <= '0;
            state     <= RESP;
          end else if (timer == TMO_LAST) begin
            resp_data     <= ERR_DATA;
            s_cyc_o       <= '0;
            s_stb_o       <= '0;
            fault_pulse_o <= 1'b1;
            if (fault_count_o != 8'hFF) fault_count_o <= fault_count_o + 8'd1;
            state         <= RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          // First RESP cycle loads the ack register; second cycle shows it and returns to IDLE.
          if (!resp_phase) begin
            wbs_ack_o  <= 1'b1;
            wbs_dat_o  <= resp_data;
            resp_phase <= 1'b1;
          end else begin
            resp_phase <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hip_wb_router.sv
// Directed bench for hip_wb_router: decode, wait states, misses, timeout, saturation, abort and reset.
module tb_hip_wb_router;

  logic          clk;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic [3:0]    s_cyc, s_stb;
  logic          s_we;
  logic [3:0]    s_sel;
  logic [15:0]   s_adr;
  logic [31:0]   s_dat;
  logic [3:0]    s_ack;
  logic [127:0]  s_dat_in;
  logic          fault_pulse;
  logic [7:0]    fault_count;

  int checks = 0;
  int errors = 0;

  // Per-access observations filled by do_access.
  int          lat, strobe_cycles, pulses, ack_count, dat_leak;
  logic [31:0] rd;
  logic [3:0]  cyc_seen, snap_cyc, snap_stb, snap_sel;
  logic [15:0] snap_adr;
  logic [31:0] snap_dat;
  logic        snap_we;

  hip_wb_router dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (wdat),
    .wbs_ack_o     (ack),
    .wbs_dat_o     (rdat),
    .s_cyc_o       (s_cyc),
    .s_stb_o       (s_stb),
    .s_we_o        (s_we),
    .s_sel_o       (s_sel),
    .s_adr_o       (s_adr),
    .s_dat_o       (s_dat),
    .s_ack_i       (s_ack),
    .s_dat_i       (s_dat_in),
    .fault_pulse_o (fault_pulse),
    .fault_count_o (fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Host request plus a simple subordinate: slot acks in strobed cycle wait_cyc+1
  // (wait_cyc < 0 never acks); noise acks go to other slots whenever strobed.
  // lat is the edge (counting the request edge as 0) where the host samples ack.
  task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input int slot, input int wait_cyc, input logic [31:0] slot_rd,
                           input logic [3:0] noise);
    bit done;
    done = 0;
    lat = 0; strobe_cycles = 0; pulses = 0; ack_count = 0; dat_leak = 0; rd = '0;
    cyc_seen = '0; snap_cyc = '0; snap_stb = '0; snap_sel = '0; snap_adr = '0;
    snap_dat = '0; snap_we = 1'b0;
    if (slot >= 0) s_dat_in[32*slot +: 32] = slot_rd;
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; wdat = wd;
    tick;
    for (int n = 0; n < 400 && !done; n++) begin
      if (fault_pulse) pulses++;
      cyc_seen |= s_cyc;
      if (ack) begin
        ack_count++;
        lat = n + 1;
        rd = rdat;
        done = 1;
      end else if (rdat != 0) dat_leak++;
      if (s_cyc != 0) begin
        strobe_cycles++;
        if (strobe_cycles == 1) begin
          snap_cyc = s_cyc; snap_stb = s_stb; snap_sel = s_sel;
          snap_adr = s_adr; snap_dat = s_dat; snap_we = s_we;
        end
      end
      s_ack = '0;
      if (s_cyc != 0) begin
        s_ack = noise;
        if (slot >= 0 && strobe_cycles == wait_cyc + 1) s_ack[slot] = 1'b1;
      end
      if (done) begin
        cyc = 1'b0; stb = 1'b0;
      end
      tick;
    end
    s_ack = '0; cyc = 1'b0; stb = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (ack) ack_count++;
      if (!ack && rdat != 0) dat_leak++;
      if (fault_pulse) pulses++;
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick; tick;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", rdat); end
    checks++; if (s_cyc !== 4'h0 || s_stb !== 4'h0) begin errors++; $display("FAIL reset_strobes: got %b/%b expected 0000", s_cyc, s_stb); end
    checks++; if (fault_count !== 8'h0 || fault_pulse !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0d/%0b expected 0/0", fault_count, fault_pulse); end
    checks++; if (s_adr !== 16'h0 || s_dat !== 32'h0) begin errors++; $display("FAIL reset_latches: got %h/%h expected 0/0", s_adr, s_dat); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_hit;
    do_access(32'h3002_0010, 1'b1, 32'h1234_5678, 2, 0, 32'h0, 4'h0);
    checks++; if (snap_cyc !== 4'b0100 || snap_stb !== 4'b0100) begin errors++; $display("FAIL wr_strobe: got %b/%b expected 0100", snap_cyc, snap_stb); end
    checks++; if (snap_adr !== 16'h0010) begin errors++; $display("FAIL wr_adr: got %h expected 0010", snap_adr); end
    checks++; if (snap_dat !== 32'h1234_5678) begin errors++; $display("FAIL wr_dat: got %h expected 12345678", snap_dat); end
    checks++; if (snap_we !== 1'b1 || snap_sel !== 4'hF) begin errors++; $display("FAIL wr_we_sel: got %b/%h expected 1/f", snap_we, snap_sel); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (ack_count !== 1) begin errors++; $display("FAIL wr_ack_pulses: got %0d expected 1", ack_count); end
    checks++; if (fault_count !== 8'd0 || pulses !== 0) begin errors++; $display("FAIL wr_fault: got %0d/%0d expected 0/0", fault_count, pulses); end
  endtask

  task automatic test_read_wait;
    do_access(32'h3001_0004, 1'b0, 32'h0, 1, 5, 32'hCAFE_F00D, 4'b1001);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data: got %h expected cafef00d", rd); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL rd_latency: got %0d expected 8", lat); end
    checks++; if (strobe_cycles !== 6) begin errors++; $display("FAIL rd_strobe_len: got %0d expected 6", strobe_cycles); end
    checks++; if (snap_cyc !== 4'b0010 || snap_adr !== 16'h0004 || snap_we !== 1'b0) begin errors++; $display("FAIL rd_decode: got %b/%h/%b expected 0010/0004/0", snap_cyc, snap_adr, snap_we); end
    checks++; if (ack_count !== 1 || dat_leak !== 0) begin errors++; $display("FAIL rd_ack_window: got %0d acks %0d leaks expected 1/0", ack_count, dat_leak); end
  endtask

  task automatic test_miss;
    do_access(32'h3005_0000, 1'b0, 32'h0, -1, -1, 32'h0, 4'h0);
    checks++; if (cyc_seen !== 4'h0) begin errors++; $display("FAIL miss_idx_strobe: got %b expected 0000", cyc_seen); end
    checks++; if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_idx_resp: got lat %0d data %h expected 2/deadbeef", lat, rd); end
    checks++; if (fault_count !== 8'd1 || pulses !== 1) begin errors++; $display("FAIL miss_idx_fault: got %0d/%0d expected 1/1", fault_count, pulses); end
    do_access(32'h4000_0000, 1'b0, 32'h0, -1, -1, 32'h0, 4'h0);
    checks++; if (cyc_seen !== 4'h0) begin errors++; $display("FAIL miss_base_strobe: got %b expected 0000", cyc_seen); end
    checks++; if (lat !== 2 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_base_resp: got lat %0d data %h expected 2/deadbeef", lat, rd); end
    checks++; if (fault_count !== 8'd2 || pulses !== 1) begin errors++; $display("FAIL miss_base_fault: got %0d/%0d expected 2/1", fault_count, pulses); end
    // Bits [23:20] are don't-care for decode.
    do_access(32'h30F3_0008, 1'b0, 32'h0, 3, 0, 32'h7777_0003, 4'h0);
    checks++; if (rd !== 32'h7777_0003 || snap_cyc !== 4'b1000) begin errors++; $display("FAIL ignore_bits: got %h/%b expected 77770003/1000", rd, snap_cyc); end
  endtask

  task automatic test_timeout;
    do_access(32'h3000_0000, 1'b0, 32'h0, 0, -1, 32'h0, 4'h0);
    checks++; if (strobe_cycles !== 255) begin errors++; $display("FAIL tmo_strobe_len: got %0d expected 255", strobe_cycles); end
    checks++; if (lat !== 257 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_resp: got lat %0d data %h expected 257/deadbeef", lat, rd); end
    checks++; if (fault_count !== 8'd3 || pulses !== 1) begin errors++; $display("FAIL tmo_fault: got %0d/%0d expected 3/1", fault_count, pulses); end
  endtask

  task automatic test_timeout_edge;
    do_access(32'h3000_0020, 1'b0, 32'h0, 0, 254, 32'h5A5A_0001, 4'h0);
    checks++; if (lat !== 257 || rd !== 32'h5A5A_0001) begin errors++; $display("FAIL edge_resp: got lat %0d data %h expected 257/5a5a0001", lat, rd); end
    checks++; if (fault_count !== 8'd3 || pulses !== 0) begin errors++; $display("FAIL edge_fault: got %0d/%0d expected 3/0", fault_count, pulses); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) do_access(32'h5000_0000, 1'b0, 32'h0, -1, -1, 32'h0, 4'h0);
    checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", fault_count); end
    checks++; if (pulses !== 1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sat_pulse: got %0d/%h expected 1/deadbeef", pulses, rd); end
  endtask

  task automatic test_abort_and_reset;
    int late_acks;
    // Reset in the middle of an ACTIVE access.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3001_0000;
    tick; tick; tick;
    checks++; if (s_cyc !== 4'b0010) begin errors++; $display("FAIL rst_pre_active: got %b expected 0010", s_cyc); end
    rst = 1'b1;
    tick;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    checks++; if (s_cyc !== 4'h0 || ack !== 1'b0 || rdat !== 32'h0) begin errors++; $display("FAIL rst_mid: got %b/%b/%h expected 0000/0/0", s_cyc, ack, rdat); end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fault_count); end
    late_acks = 0;
    for (int i = 0; i < 4; i++) begin if (ack) late_acks++; tick; end
    checks++; if (late_acks !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d expected 0", late_acks); end
    // Host abort: cyc drops while ACTIVE.
    cyc = 1'b1; stb = 1'b1; adr = 32'h3002_0000;
    tick; tick; tick;
    cyc = 1'b0; stb = 1'b0;
    tick;
    checks++; if (s_cyc !== 4'h0 || s_stb !== 4'h0 || ack !== 1'b0 || fault_pulse !== 1'b0) begin errors++; $display("FAIL abort_mid: got %b/%b/%b/%b expected 0000/0000/0/0", s_cyc, s_stb, ack, fault_pulse); end
    late_acks = 0;
    for (int i = 0; i < 4; i++) begin if (ack || fault_pulse) late_acks++; tick; end
    checks++; if (late_acks !== 0 || fault_count !== 8'd0) begin errors++; $display("FAIL abort_quiet: got %0d/%0d expected 0/0", late_acks, fault_count); end
    do_access(32'h3003_00FC, 1'b0, 32'h0, 3, 0, 32'h0BAD_F00D, 4'h0);
    checks++; if (lat !== 3 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL after_abort: got lat %0d data %h expected 3/0badf00d", lat, rd); end
  endtask

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    s_ack = '0;
    s_dat_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    test_reset;
    test_write_hit;
    test_read_wait;
    test_miss;
    test_timeout;
    test_timeout_edge;
    test_saturation;
    test_abort_and_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hip_wb_router.md
Name: hip_wb_router

Overview:
Single-master Wishbone router between the Caravel management-SoC slave port and the home-inventory subordinate blocks (sensor regs, ADC sequencer, event log, ...). It decodes each host access to one of N_SLAVES windows and forwards it as a registered single-outstanding transaction. It returns the subordinate's data and ack to the host. Accesses that hit no valid window, or that go unanswered for too long, get an error-data ack so the host bus never hangs. It also counts those faults.

Parameters:
N_SLAVES, 4, number of subordinate windows (1..16)
BASE_HI, 8'h30, required value of wbs_adr_i[31:24] for any hit
TIMEOUT_CYCLES, 255, ACTIVE cycles without s_ack_i before forced error response (1..65535)
ERR_DATA, 32'hDEAD_BEEF, read data returned on decode miss or timeout

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  host Wishbone controls
wbs_sel_i  in  4  host byte selects
wbs_adr_i  in  32  host byte address
wbs_dat_i  in  32  host write data
wbs_ack_o  out  1  host ack, registered, one-cycle pulse
wbs_dat_o  out  32  host read data, valid while wbs_ack_o=1, else 0
s_cyc_o  out  N_SLAVES  per-subordinate cycle (one-hot or zero)
s_stb_o  out  N_SLAVES  per-subordinate strobe (equals s_cyc_o)
s_we_o  out  1  latched write enable
s_sel_o  out  4  latched byte selects
s_adr_o  out  16  latched wbs_adr_i[15:0] (window offset)
s_dat_o  out  32  latched write data
s_ack_i  in  N_SLAVES  per-subordinate ack
s_dat_i  in  32*N_SLAVES  per-subordinate read data, slot k at [32k+31:32k]
fault_pulse_o  out  1  one-cycle pulse on each miss or timeout
fault_count_o  out  8  saturating fault counter

Behaviour:
- Reset: FSM=IDLE. All outputs = 0. Latches, timer and fault_count_o are cleared. Reset has priority in every state and aborts any in-flight access with no host ack.
- Decode: idx = wbs_adr_i[19:16]. Hit iff wbs_adr_i[31:24]==BASE_HI and idx<N_SLAVES. Bits [23:20] are ignored.
- FSM states are IDLE, ACTIVE and RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, latch we, sel, adr[15:0], dat and idx.
  - On a hit, go to ACTIVE and set s_cyc_o[idx]=s_stb_o[idx]=1 from the next cycle. Clear the timer.
  - On a miss, go to RESP with response data ERR_DATA. Pulse fault_pulse_o and increment the fault counter.
- ACTIVE:
  - Hold the strobes and latched fields constant.
  - If s_ack_i[idx]=1: capture s_dat_i slot idx (writes capture the same; host ignores it). Drop the strobes on the next edge and go to RESP.
  - Otherwise increment the timer. When the timer reaches TIMEOUT_CYCLES-1 with no ack: drop the strobes, set response data ERR_DATA, pulse fault_pulse_o, count the fault and go to RESP.
  - If wbs_cyc_i falls (host abort): drop the strobes and go to IDLE with no ack and no fault.
  - Acks on s_ack_i bits other than idx are ignored in every state.
- RESP: wbs_ack_o=1 and wbs_dat_o=response for exactly one cycle, then go to IDLE. A new request is accepted in IDLE on the cycle after RESP (the host has deasserted stb by then).
- Latency:
  - A hit whose subordinate acks in its first strobed cycle gives wbs_ack_o 3 cycles after the request is sampled (IDLE→ACTIVE→RESP).
  - A miss gives wbs_ack_o 2 cycles after the request is sampled.
  - A timeout gives wbs_ack_o at TIMEOUT_CYCLES+2 cycles.
- Fault counter: saturates at 255 and does not wrap. fault_pulse_o fires even when the counter is saturated.
- Ack coincides with the timeout edge: the ack wins. Real data is returned and no fault is recorded.
- Only one transaction is outstanding at a time. wbs_ack_o is never asserted outside RESP.

Test Plan:
- Write 0x3002_0010 data 0x1234_5678 sel 0xF, slot 2 acks after 1 cycle → s_cyc_o=0100, s_adr_o=0x0010, s_dat_o=0x12345678 during ACTIVE. One wbs_ack_o pulse 3 cycles after request; fault_count_o=0.
- Read 0x3001_0004, slot 1 returns 0xCAFE_F00D after 5 wait cycles → wbs_dat_o=0xCAFEF00D for exactly the ack cycle, 0 otherwise. s_ack_i pulses on slots 0/3 during the access are ignored.
- Read 0x3005_0000 (idx 5 ≥ N_SLAVES) and read 0x4000_0000 → no s_cyc_o activity. Ack after 2 cycles with 0xDEADBEEF each; fault_count_o=2, two fault_pulse_o pulses.
- Read slot 0 that never acks, TIMEOUT_CYCLES=255 → strobe high for exactly 255 cycles. wbs_ack_o at cycle 257 with 0xDEADBEEF; fault_count_o increments.
- Timeout edge case: slot 0 acks on the final timeout cycle → real data returned, no fault. Then drive 300 consecutive misses → fault_count_o holds at 255.
- wb_rst_i asserted mid-ACTIVE, and separately wbs_cyc_i dropped mid-ACTIVE → all outputs 0 next cycle, no ack. A following hit access completes normally.
